// File: rtl/stopwatch_display_pkg.sv
// Shared constants for the stopwatch seven-segment display driver:
// digit indices, active-low segment patterns, decimal-point mask, field limits.
package stopwatch_display_pkg;

   localparam int unsigned NUM_DIGITS = 6;

   typedef enum logic [2:0] {
      IDX_HUN_ONES = 3'd0,
      IDX_HUN_TENS = 3'd1,
      IDX_SEC_ONES = 3'd2,
      IDX_SEC_TENS = 3'd3,
      IDX_MIN_ONES = 3'd4,
      IDX_MIN_TENS = 3'd5
   } digit_idx_t;

   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Bit set = decimal point lit after that digit (secs ones, mins ones)
   localparam logic [NUM_DIGITS-1:0] DP_MASK = 6'b010100;

   localparam logic [6:0] LIMIT_MINS = 7'd59;
   localparam logic [6:0] LIMIT_SECS = 7'd59;
   localparam logic [6:0] LIMIT_HUN  = 7'd99;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      seg_of = SEG_BLANK;
      for (int unsigned i = 0; i < 10; i++) begin
         if (d == 4'(i)) seg_of = SEG_DIGIT[i];
      end
   endfunction

endpackage

// File: rtl/bin_to_bcd99.sv
// Combinational split of a 0..99 binary value into tens/ones BCD digits,
// with a flag raised when the value exceeds the supplied limit.
module bin_to_bcd99
   import stopwatch_display_pkg::*;
(
   input  logic [6:0] bin,
   input  logic [6:0] limit,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       oor
);

   always_comb begin
      oor  = (bin > limit);
      tens = 4'(bin / 7'd10);
      ones = 4'(bin % 7'd10);
      if (oor) begin
         tens = '0;
         ones = '0;
      end
   end

endmodule

// File: rtl/stopwatch_display.sv
// Scanned 6-digit MM.SS.HH common-anode display driver with frame snapshots.
// Optional leading-zero blanking of minutes tens: STOPWATCH_DISPLAY_LZ_BLANK_EN.
module stopwatch_display
   import stopwatch_display_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 50_000,
   parameter int unsigned GUARD    = 16
)
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] mins,
   input  logic [5:0] secs,
   input  logic [6:0] hundredths,
   input  logic       blank,
   output logic [6:0] seg,
   output logic       dp,
   output logic [5:0] an
);

   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] PRESC_GUARD = PW'(GUARD);

   logic [PW-1:0] presc;
   digit_idx_t    idx;
   logic [5:0]    snap_mins;
   logic [5:0]    snap_secs;
   logic [6:0]    snap_hun;

   logic [3:0] min_tens, min_ones, sec_tens, sec_ones, hun_tens, hun_ones;
   logic       min_oor, sec_oor, hun_oor;

   logic [3:0] digit_val;
   logic       field_oor;
   logic       lz_hide;
   logic       show;
   logic [6:0] seg_nxt;
   logic       dp_nxt;
   logic [5:0] an_nxt;

   bin_to_bcd99 u_bcd_mins (
      .bin   ({1'b0, snap_mins}),
      .limit (LIMIT_MINS),
      .tens  (min_tens),
      .ones  (min_ones),
      .oor   (min_oor)
   );

   bin_to_bcd99 u_bcd_secs (
      .bin   ({1'b0, snap_secs}),
      .limit (LIMIT_SECS),
      .tens  (sec_tens),
      .ones  (sec_ones),
      .oor   (sec_oor)
   );

   bin_to_bcd99 u_bcd_hun (
      .bin   (snap_hun),
      .limit (LIMIT_HUN),
      .tens  (hun_tens),
      .ones  (hun_ones),
      .oor   (hun_oor)
   );

   always_comb begin
      digit_val = '0;
      field_oor = 1'b0;
      lz_hide   = 1'b0;
      unique case (idx)
         IDX_HUN_ONES: begin digit_val = hun_ones; field_oor = hun_oor; end
         IDX_HUN_TENS: begin digit_val = hun_tens; field_oor = hun_oor; end
         IDX_SEC_ONES: begin digit_val = sec_ones; field_oor = sec_oor; end
         IDX_SEC_TENS: begin digit_val = sec_tens; field_oor = sec_oor; end
         IDX_MIN_ONES: begin digit_val = min_ones; field_oor = min_oor; end
         IDX_MIN_TENS: begin
            digit_val = min_tens;
            field_oor = min_oor;
`ifdef STOPWATCH_DISPLAY_LZ_BLANK_EN
            lz_hide   = (snap_mins < 6'd10);
`endif
         end
         default: ;
      endcase

      // Guard window, blank request and leading-zero hide all force anodes off
      show    = (presc >= PRESC_GUARD) && !blank && !lz_hide;
      seg_nxt = SEG_BLANK;
      dp_nxt  = 1'b1;
      an_nxt  = '1;
      if (show) begin
         seg_nxt = field_oor ? SEG_DASH : seg_of(digit_val);
         dp_nxt  = ~DP_MASK[idx];
         an_nxt  = ~(6'b000001 << idx);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc     <= '0;
         idx       <= IDX_HUN_ONES;
         snap_mins <= '0;
         snap_secs <= '0;
         snap_hun  <= '0;
         seg       <= SEG_BLANK;
         dp        <= 1'b1;
         an        <= '1;
      end else begin
         seg <= seg_nxt;
         dp  <= dp_nxt;
         an  <= an_nxt;
         if (presc == PRESC_LAST) begin
            presc <= '0;
            // Snapshot only on frame wrap so every digit of a frame is coherent
            if (idx == IDX_MIN_TENS) begin
               idx       <= IDX_HUN_ONES;
               snap_mins <= mins;
               snap_secs <= secs;
               snap_hun  <= hundredths;
            end else begin
               idx <= digit_idx_t'(idx + 3'd1);
            end
         end else begin
            presc <= presc + PW'(1);
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_display.sv
// Scoreboard bench for stopwatch_display: per-cycle expectations from a
// time-based reference model, checked by an independent monitor process.
module tb_stopwatch_display;

   localparam int unsigned SCAN_DIV = 8;
   localparam int unsigned GUARD    = 2;
   localparam int unsigned FRAME    = SCAN_DIV * 6;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [5:0] mins = '0;
   logic [5:0] secs = '0;
   logic [6:0] hundredths = '0;
   logic       blank = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [5:0] an;

   stopwatch_display #(.SCAN_DIV(SCAN_DIV), .GUARD(GUARD)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .mins       (mins),
      .secs       (secs),
      .hundredths (hundredths),
      .blank      (blank),
      .seg        (seg),
      .dp         (dp),
      .an         (an)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned k;
      logic [13:0] exp;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int unsigned k = 0;
   int unsigned m_snap = 0, s_snap = 0, h_snap = 0;

   // Output expected after posedge kk (1-based since reset release)
   function automatic logic [13:0] model_out(input int unsigned kk, input int unsigned m,
                                             input int unsigned s, input int unsigned h,
                                             input bit b);
      logic [6:0] segs [0:9];
      int unsigned slot, pos, v, lim, d;
      logic [6:0] sg;
      logic       dpv;
      logic [5:0] anv;
      segs = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      pos  = (kk - 1) % SCAN_DIV;
      slot = ((kk - 1) / SCAN_DIV) % 6;
      if (pos < GUARD || b) return {7'h7F, 1'b1, 6'h3F};
`ifdef STOPWATCH_DISPLAY_LZ_BLANK_EN
      if (slot == 5 && m < 10) return {7'h7F, 1'b1, 6'h3F};
`endif
      case (slot / 2)
         0:       begin v = h; lim = 99; end
         1:       begin v = s; lim = 59; end
         default: begin v = m; lim = 59; end
      endcase
      d   = (slot % 2 == 0) ? v % 10 : (v / 10) % 10;
      sg  = (v > lim) ? 7'h3F : segs[d];
      dpv = (slot == 2 || slot == 4) ? 1'b0 : 1'b1;
      anv = 6'h3F & ~(6'd1 << slot);
      return {sg, dpv, anv};
   endfunction

   // Entered at a negedge; sets inputs for the next posedge and records its expectation
   task automatic drive_cycle(input int unsigned m, input int unsigned s,
                              input int unsigned h, input bit b);
      exp_t e;
      mins       = 6'(m);
      secs       = 6'(s);
      hundredths = 7'(h);
      blank      = b;
      k++;
      e.k   = k;
      e.exp = model_out(k, m_snap, s_snap, h_snap, b);
      sb.push_back(e);
      if (k % FRAME == 0) begin
         m_snap = m % 64;
         s_snap = s % 64;
         h_snap = h % 128;
      end
      @(negedge clk);
   endtask

   task automatic check_reset(input string tag);
      checks++;
      if (seg !== 7'h7F) begin
         failures++;
         $display("FAIL %s_seg got=%h want=7f", tag, seg);
      end
      checks++;
      if (dp !== 1'b1) begin
         failures++;
         $display("FAIL %s_dp got=%b want=1", tag, dp);
      end
      checks++;
      if (an !== 6'h3F) begin
         failures++;
         $display("FAIL %s_an got=%h want=3f", tag, an);
      end
   endtask

   // Monitor: one registered output word per clock, compared against the queue head
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({seg, dp, an} !== e.exp) begin
               failures++;
               $display("FAIL out k=%0d got seg=%h dp=%b an=%h want seg=%h dp=%b an=%h",
                        e.k, seg, dp, an, e.exp[13:7], e.exp[6], e.exp[5:0]);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned rm, rs, rh;
      bit          rb;
      rm = 30; rs = 20; rh = 50; rb = 1'b0;

      repeat (3) @(negedge clk);
      check_reset("reset_init");
      reset_n = 1'b1;

      repeat (96) drive_cycle(12, 34, 56, 1'b0);
      repeat (26) drive_cycle(12, 34, 56, 1'b0);
      repeat (70) drive_cycle(12, 35, 0, 1'b0);
      repeat (96) drive_cycle(12, 60, 127, 1'b0);
      repeat (96) drive_cycle(7, 5, 9, 1'b0);
      repeat (20) drive_cycle(7, 5, 9, 1'b0);
      repeat (10) drive_cycle(7, 5, 9, 1'b1);
      repeat (30) drive_cycle(7, 5, 9, 1'b0);

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            rm = $urandom_range(0, 63);
            rs = $urandom_range(0, 63);
            rh = $urandom_range(0, 127);
         end
         if ($urandom_range(0, 15) == 0) rb = ~rb;
         drive_cycle(rm, rs, rh, rb);
      end

      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset("reset_mid");
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL pending_at_reset got=%0d want=0", sb.size());
         sb.delete();
      end
      repeat (3) @(negedge clk);
      check_reset("reset_hold");

      k = 0; m_snap = 0; s_snap = 0; h_snap = 0;
      reset_n = 1'b1;
      repeat (100) drive_cycle(23, 45, 67, 1'b0);
      repeat (60) drive_cycle(3, 9, 99, 1'b0);

      @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d want=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stopwatch_display.md
# stopwatch_display

Scanned 6-digit seven-segment driver that consumes the stopwatch's `mins`, `secs` and `hundredths` counts and renders them as `MM.SS.HH` on a common-anode multiplexed display. It sits directly downstream of the stopwatch counter block and drives the board display pins. It handles binary-to-BCD conversion and digit scanning. It takes frame-coherent snapshots so a digit never tears while the counts roll over.

## Interface
- `SCAN_DIV`, 50_000: clock cycles per digit slot (1 kHz slot rate at 50 MHz). Must be ≥ 2.
- `GUARD`, 16: cycles at the start of each slot with all anodes off (anti-ghosting). Must satisfy 0 ≤ `GUARD` < `SCAN_DIV`.
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `mins` in 6: minutes, binary, valid range 0–59.
- `secs` in 6: seconds, binary, valid range 0–59.
- `hundredths` in 7: centiseconds, binary, valid range 0–99.
- `blank` in 1: synchronous display-off request; the counters keep running while it is asserted.
- `seg` out 7: segment drive, active-low, bit order {g,f,e,d,c,b,a}.
- `dp` out 1: decimal point drive, active-low.
- `an` out 6: anode enables, active-low. `an[0]` is the rightmost digit (hundredths ones); `an[5]` is minutes tens.

## Operation
- Prescaler counts 0..`SCAN_DIV`-1 and wraps. On each wrap, the digit index advances 0→1→…→5→0.
- **Snapshot.** `mins`, `secs` and `hundredths` are sampled into snapshot registers on the cycle the index moves 5→0. Every digit of a frame comes from one snapshot.
- **Digit mapping by index.**
  - 0: hundredths ones
  - 1: hundredths tens
  - 2: secs ones (`dp`=0)
  - 3: secs tens
  - 4: mins ones (`dp`=0)
  - 5: mins tens
  - `dp`=1 at all other indices.
- **BCD conversion.** Each field is split into tens and ones, each 0–9.
- **Out-of-range fields.** If a field exceeds its valid range (mins or secs > 59, hundredths > 99), both of its digits show dash.
- **Active-low encodings.**
  - Digits: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10
  - dash=0x3F, blank=0x7F
- **Anode drive.** `an` is one-hot-low on the current index only when the prescaler ≥ `GUARD` and `blank`=0. Otherwise `an`=0x3F.
- **While `an` is all-high:** `seg`=0x7F and `dp`=1.

## Timing
- All outputs are registered. The outputs in cycle t+1 reflect the prescaler, index and snapshot values of cycle t.
- **Reset values** (immediate on `reset_n` low, held until release): `seg`=0x7F, `dp`=1, `an`=0x3F, prescaler=0, index=0, snapshot=0.
- After release, the index 0 anode first asserts at cycle `GUARD`+1. With `GUARD`=0 it asserts at cycle 1.
- **Snapshot timing.** Inputs changed mid-frame appear in the next frame only. The first frame after reset shows the zero snapshot. The first live sample is taken at the first 5→0 wrap.
- **`blank` timing.** `blank` takes effect on the next cycle. Deasserting it resumes display within the current slot, honouring the guard window.
- **Reset mid-operation.** Asserting `reset_n` during a slot aborts it. On release, scanning restarts at index 0 with the guard interval.

## Configuration
- Macro: `STOPWATCH_DISPLAY_LZ_BLANK_EN`.
- **Defined:** when the snapshot minutes < 10, index 5 is blanked (`an[5]` stays high, `seg`=0x7F) for the whole slot.
- **Undefined:** minutes tens always shows its digit, including 0 (0x40).

## Structure
- **Package `stopwatch_display_pkg`** contains:
  - digit count (6)
  - segment constants: `SEG_DIGIT[0:9]`, `SEG_DASH`, `SEG_BLANK`
  - per-index `dp` mask (6'b010100)
  - field range limits (59, 59, 99)
- **Sub-module `bin_to_bcd99`** (combinational): 7-bit binary plus limit in → tens, ones, and out-of-range flag. It is instantiated three times, once per field.
- The top level holds the prescaler, index counter, snapshot registers, digit mux and output registers.

## Test plan
All scenarios use `SCAN_DIV`=8 and `GUARD`=2.
- **Reset.** Assert `reset_n` mid-slot → `seg`=0x7F, `dp`=1, `an`=0x3F in the same cycle. After release, `an`=0x3E first at cycle 3.
- **Normal display.** Hold 12:34.56 for two frames → second frame shows, by index 0..5:
  - `seg` = 0x02, 0x12, 0x19, 0x30, 0x24, 0x79
  - `dp`=0 only at indices 2 and 4
- **Snapshot coherence.** Change inputs from 12:34.56 to 12:35.00 during index 3 → the rest of that frame still shows 34.56. The next frame shows 0x40, 0x40, 0x12, 0x30.
- **Out of range.** `secs`=60, `hundredths`=127 → indices 0–3 show `seg`=0x3F. Minutes digits stay correct.
- **Leading-zero blanking.** `mins`=7:
  - with `STOPWATCH_DISPLAY_LZ_BLANK_EN`: `an[5]` never low.
  - without it: index 5 shows 0x40.
- **Blank input.** Assert `blank` for 10 cycles mid-frame → `an`=0x3F next cycle. The index keeps advancing. After deassert, `an` resumes on the correct index.
